if_id_queue: RTL and testbench

Instruction buffer between the fetch stage and decode. Captures each fetched {instruction, PC+2} pair into a DEPTH-entry FIFO and presents the oldest entry to decode with a valid/ready handshake. Drives the fetch stage's PC write enable, stalling fetch when the buffer is full. Discards all buffered wrong-path instructions on a taken branch.

---
 rtl/if_id_queue_if.sv | 24 ++
 rtl/if_id_queue.sv | 77 +++++++
 tb/tb_if_id_queue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the instruction buffer
interface if_id_queue_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] instruc;
  logic [WIDTH-1:0] seq_PC;
  logic             flush;
  logic             en_PC;
  logic             dec_valid;
  logic             dec_ready;
  logic [WIDTH-1:0] dec_instruc;
  logic [WIDTH-1:0] dec_seq_PC;

  // master is the pipeline around the buffer, slave is the buffer itself
  modport master (
    output instruc, seq_PC, flush, dec_ready,
    input  en_PC, dec_valid, dec_instruc, dec_seq_PC
  );

  modport slave (
    input  instruc, seq_PC, flush, dec_ready,
    output en_PC, dec_valid, dec_instruc, dec_seq_PC
  );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID instruction FIFO with fetch stall and branch flush
// Optional HALT detection enabled by defining IF_ID_HALT_DETECT_EN.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  if_id_queue_if.slave           bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   halted
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // push looks only at current occupancy so en_PC never depends on dec_ready
  assign push = ~full & ~bus.flush & ~halted;
  assign pop  = ~empty & bus.dec_ready & ~bus.flush;

  assign bus.en_PC     = push | bus.flush;
  assign bus.dec_valid = ~empty;
  assign {bus.dec_instruc, bus.dec_seq_PC} = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bus.instruc, bus.seq_PC};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef IF_ID_HALT_DETECT_EN
  // the HALT word itself is queued; only later fetches are frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (bus.flush) begin
      halted <= 1'b0;
    end else if (push && (bus.instruc[15:11] == 5'b00000)) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue with a queue-based reference model
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                   halted;

  if_id_queue_if #(.WIDTH(WIDTH)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .count  (count),
    .halted (halted)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];
  int          model_count = 0;
  bit          m_halted = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares the presented head against the scoreboard, pops on handshake
  always @(negedge clk) begin
    if (!rst) begin
      check("dec_valid", 32'(bus.dec_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("head", {bus.dec_instruc, bus.dec_seq_PC}, exp_q[0]);
        if (bus.dec_ready && !bus.flush) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic [15:0] ins, input logic [15:0] pc, input bit fl, input bit rdy);
    bit m_push;
    bit m_pop;
    bus.instruc   = ins;
    bus.seq_PC    = pc;
    bus.flush     = fl;
    bus.dec_ready = rdy;
    m_push = (model_count < DEPTH) && !fl && !m_halted;
    m_pop  = (model_count > 0) && rdy && !fl;
    @(negedge clk);
    check("en_PC", 32'(bus.en_PC), 32'(m_push || fl));
    check("count", 32'(count), 32'(model_count));
    check("halted", 32'(halted), 32'(m_halted));
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      model_count = 0;
      m_halted    = 1'b0;
    end else begin
      if (m_push) begin
        exp_q.push_back({ins, pc});
`ifdef IF_ID_HALT_DETECT_EN
        if (ins[15:11] == 5'b00000) m_halted = 1'b1;
`endif
      end
      model_count = model_count + int'(m_push) - int'(m_pop);
    end
    #1;
  endtask

  // asserts rst between edges and checks outputs before any clock edge arrives
  task automatic reset_mid();
    bus.flush     = 1'b0;
    bus.dec_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dec_instruc", 32'(bus.dec_instruc), 32'h0000);
    check("rst_dec_seq_PC", 32'(bus.dec_seq_PC), 32'h0000);
    check("rst_en_PC", 32'(bus.en_PC), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    exp_q.delete();
    model_count = 0;
    m_halted    = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] ins;
    bus.instruc   = '0;
    bus.seq_PC    = '0;
    bus.flush     = 1'b0;
    bus.dec_ready = 1'b0;
    #1;
    reset_mid();

    // fill with decode stalled
    for (int i = 1; i <= 5; i++) step(16'(16'hA000 + i), 16'(2 * i), 1'b0, 1'b0);
    check("fill_count", 32'(count), 32'd4);
    check("fill_head", 32'(bus.dec_instruc), 32'hA001);

    // full queue, single-cycle pop, then the stalled fetch is captured
    step(16'hA005, 16'h000A, 1'b0, 1'b1);
    step(16'hA005, 16'h000A, 1'b0, 1'b0);
    step(16'hA006, 16'h000C, 1'b0, 1'b0);

    // flush with three entries queued
    step(16'h1111, 16'h0040, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(16'(16'hB001 + i), 16'(16'h0100 + 2 * i), 1'b0, 1'b0);
    step(16'hBEEF, 16'h0106, 1'b1, 1'b1);

    // steady streaming wraps the pointers
    for (int i = 0; i < 12; i++) step(16'(16'hC000 + i), 16'(16'h0200 + 2 * i), 1'b0, 1'b1);

    // asynchronous reset with three entries queued
    step(16'hC100, 16'h0300, 1'b0, 1'b0);
    step(16'hC101, 16'h0302, 1'b0, 1'b0);
    reset_mid();

    // HALT word: frozen fetch with the macro, ordinary instruction without it
    step(16'h0000, 16'h0400, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(16'(16'hD001 + i), 16'(16'h0402 + 2 * i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(16'hD100, 16'h0410, 1'b0, 1'b1);
    step(16'hD200, 16'h0500, 1'b1, 1'b0);
    step(16'hE001, 16'h0600, 1'b0, 1'b1);
    step(16'hE002, 16'h0602, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ins[15:11] = 5'b00000;
      step(ins, 16'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
